// File: rtl/vga_pkg.sv
// Shared geometry, colour and FSM definitions for the VGA cell renderer.
// No logic; constants and types only.
// Cell grid is derived from the active area and the cell edge size.
package vga_pkg;

  localparam int H_ACTIVE   = 800;
  localparam int V_ACTIVE   = 600;
  localparam int CELL_SHIFT = 5;
  localparam int COLS       = H_ACTIVE >> CELL_SHIFT;
  // Last row is partial (lines 576-599), so round up
  localparam int ROWS       = (V_ACTIVE + (1 << CELL_SHIFT) - 1) >> CELL_SHIFT;
  localparam int ADDR_W     = 9;
  localparam int CELLS      = COLS * ROWS;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/cell_ram.sv
// Cell colour store: one write port, one synchronous read port.
// Read data is valid one cycle after the read address is presented.
// A same-cycle write to the read address returns the old word.
module cell_ram
  import vga_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [2:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [2:0]        rdata_o
);

  logic [2:0] mem_q [2**ADDR_W];

  // Write and read in one clocked block so a collision reads the previous word
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/vga_cell_renderer.sv
// Pixel stage behind the VGA timing driver: rebuilds x/y from the syncs and
// colours each pixel from a 25x19 grid of 32x32 cells held in a small RAM.
// Latency 2 cycles for RGB and syncs; writes are refused while wr_ready=0.
module vga_cell_renderer
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              color_en_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_data,
  output logic              wr_ready,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              red,
  output logic              green,
  output logic              blue
);

  state_t            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              wr_ready_q;

  logic [9:0]        x_q, y_q;
  logic              color_en_q, vsync_q;

  logic [9:0]        col, row;
  logic [ADDR_W:0]   addr_d;
  logic              vld_d;

  logic [ADDR_W-1:0] addr_s1_q;
  logic              vld_s1_q, vld_s2_q;
  logic              hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [2:0]        ram_wdata, ram_rdata, rgb;

  // Post-reset clear sweeps every RAM word once, then opens the write port for good
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (&clr_addr_q) begin
            state_q    <= ST_RUN;
            wr_ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write port: clear has priority; processor writes outside the grid are dropped
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_q;
    ram_wdata = BLACK;
    if (state_q == ST_CLEAR) begin
      ram_we = 1'b1;
    end else if (wr_en && wr_ready_q && (wr_addr < ADDR_W'(CELLS))) begin
      ram_we    = 1'b1;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
    end
  end

  // Position tracker: x counts active pixels, line end bumps y, vsync rise rewinds y
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      color_en_q <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      color_en_q <= color_en_in;
      vsync_q    <= vsync_in;
      if (color_en_in) begin
        x_q <= x_q + 10'd1;
      end else if (color_en_q) begin
        x_q <= '0;
        if (y_q != 10'h3FF) y_q <= y_q + 10'd1;
      end
      if (vsync_in && !vsync_q) y_q <= '0;
    end
  end

  // Cell index row*25+col from shifts and adds, using the pre-update position
  always_comb begin
    col    = x_q >> CELL_SHIFT;
    row    = y_q >> CELL_SHIFT;
    addr_d = (row << 4) + (row << 3) + row + col;
    // The top address bit can only be set off-grid, so it also vetoes the pixel
    vld_d  = color_en_in && (row < 10'(ROWS)) && (col < 10'(COLS)) && !addr_d[ADDR_W];
  end

  // Two-stage pipe: S1 holds the read address, S2 lines up with the RAM output
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_s1_q <= '0;
      vld_s1_q  <= 1'b0;
      vld_s2_q  <= 1'b0;
      hs_s1_q   <= 1'b0;
      hs_s2_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
    end else begin
      addr_s1_q <= addr_d[ADDR_W-1:0];
      vld_s1_q  <= vld_d;
      vld_s2_q  <= vld_s1_q;
      hs_s1_q   <= hsync_in;
      hs_s2_q   <= hs_s1_q;
      vs_s1_q   <= vsync_in;
      vs_s2_q   <= vs_s1_q;
    end
  end

  cell_ram u_cell_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (addr_s1_q),
    .rdata_o (ram_rdata)
  );

  // Black outside the grid, outside active video and while the clear is running
  assign rgb = (vld_s2_q && wr_ready_q) ? ram_rdata : BLACK;

  assign {red, green, blue} = rgb;
  assign hsync_out          = hs_s2_q;
  assign vsync_out          = vs_s2_q;
  assign wr_ready           = wr_ready_q;

endmodule
